// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch stage and its neighbours.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    localparam int          INSN_WIDTH  = 32;
    localparam int          PC_WIDTH    = 32;
    localparam logic [31:0] START_ADDR  = 32'h8002_0000;   // program load base
    localparam logic [1:0]  ACCESS_WORD = 2'b00;            // single-word access
    localparam logic        RW_READ     = 1'b0;

    // Fetch sequencing: one request outstanding at most.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of redirect, memory-port and decode-handshake signals around fetch_unit.
// Latency: n/a (wiring only).
// Backpressure: carries mem_busy (memory side) and insn_ready (decode side).
//
// master: the fetch stage.  slave: memory, decode and redirect source together.
interface fetch_unit_if
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH = PC_WIDTH,
    parameter int DATA_WIDTH = INSN_WIDTH
);
    // redirect from downstream
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    // memory instruction port
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [1:0]            mem_access_size;
    logic                  mem_rw;
    logic                  mem_enable;
    logic                  mem_busy;
    logic [DATA_WIDTH-1:0] mem_data_out;
    // decode handshake
    logic                  insn_valid;
    logic [DATA_WIDTH-1:0] insn;
    logic [ADDR_WIDTH-1:0] insn_pc;
    logic                  insn_ready;

    modport master (
        input  redirect_valid, redirect_pc,
        output mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable,
        input  mem_busy, mem_data_out,
        output insn_valid, insn, insn_pc,
        input  insn_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable,
        output mem_busy, mem_data_out,
        input  insn_valid, insn, insn_pc,
        output insn_ready
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: holds the PC, issues single-word reads, hands {insn, insn_pc} to decode.
// Latency: 3 cycles per instruction best case (FETCH, WAIT, HOLD with insn_ready).
// Backpressure: mem_busy holds the request stable; insn_ready=0 holds the instruction indefinitely.
//
// Ports: clock, reset_n (async active-low); fu = fetch_unit_if.master carrying
// redirect_valid/redirect_pc, the memory request/response signals and the
// insn_valid/insn/insn_pc/insn_ready handshake. All outputs are registered.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = mips_pkg::PC_WIDTH,
    parameter int                    DATA_WIDTH = mips_pkg::INSN_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = mips_pkg::START_ADDR
) (
    input  logic              clock,
    input  logic              reset_n,
    fetch_unit_if.master      fu
);
    import mips_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] insn_q, insn_d;
    logic [ADDR_WIDTH-1:0] insn_pc_q, insn_pc_d;
    logic                  insn_valid_q, insn_valid_d;
    logic                  mem_enable_q, mem_enable_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        insn_d        = insn_q;
        insn_pc_d     = insn_pc_q;
        insn_valid_d  = insn_valid_q;

        unique case (state_q)
            IDLE: begin
                // reset-release cycle: nothing issued yet
                state_d = FETCH;
            end
            FETCH: begin
                if (!fu.mem_busy) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // read data is valid exactly one cycle after acceptance
                insn_d       = fu.mem_data_out;
                insn_pc_d    = pc_q;
                insn_valid_d = 1'b1;
                pc_d         = pc_q + PC_STEP;   // wraps modulo 2^ADDR_WIDTH
                state_d      = HOLD;
            end
            HOLD: begin
                if (fu.insn_ready) begin
                    insn_valid_d = 1'b0;
                    state_d      = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides everything outside IDLE: a pending read's data or
        // a held instruction is dropped and fetch restarts at the target.
        // insn/insn_pc keep their last captured values.
        if (fu.redirect_valid && (state_q != IDLE)) begin
            pc_d         = fu.redirect_pc & ALIGN_MASK;
            insn_d       = insn_q;
            insn_pc_d    = insn_pc_q;
            insn_valid_d = 1'b0;
            state_d      = FETCH;
        end

        // Request outputs are registered, so derive them from the next state.
        // The address is held outside FETCH; only mem_enable qualifies it.
        mem_enable_d  = (state_d == FETCH);
        mem_address_d = (state_d == FETCH) ? pc_d : mem_address_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= START_ADDR;
            insn_q        <= '0;
            insn_pc_q     <= '0;
            insn_valid_q  <= 1'b0;
            mem_enable_q  <= 1'b0;
            mem_address_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            insn_q        <= insn_d;
            insn_pc_q     <= insn_pc_d;
            insn_valid_q  <= insn_valid_d;
            mem_enable_q  <= mem_enable_d;
            mem_address_q <= mem_address_d;
        end
    end

    assign fu.mem_address     = mem_address_q;
    assign fu.mem_data_in     = '0;
    assign fu.mem_access_size = ACCESS_WORD;
    assign fu.mem_rw          = RW_READ;
    assign fu.mem_enable      = mem_enable_q;
    assign fu.insn_valid      = insn_valid_q;
    assign fu.insn            = insn_q;
    assign fu.insn_pc         = insn_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic against a
// transaction-level model (next PC decode must see, memory contents by address).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fetch_unit;
    import mips_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) fu_if ();

    fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .START_ADDR(32'h8002_0000)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .fu      (fu_if)
    );

    int checks      = 0;
    int errors      = 0;
    int mem_accepts = 0;

    // Memory image: preloaded word at the load base, address-derived pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8002_0000) return 32'h27BD_FFF8;
        return {a[15:0] ^ 16'hC3A5, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Memory model: a request accepted at a posedge returns its data the cycle after.
    always @(posedge clock) begin
        if (fu_if.mem_enable && !fu_if.mem_busy) begin
            fu_if.mem_data_out <= mem_word(fu_if.mem_address);
            mem_accepts        <= mem_accepts + 1;
        end
    end

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        fu_if.redirect_valid = 1'b0;
        fu_if.redirect_pc    = '0;
        fu_if.mem_busy       = 1'b0;
        fu_if.insn_ready     = 1'b1;
        reset_n              = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (fu_if.insn_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", fu_if.insn_valid); end
        checks++; if (fu_if.insn !== 32'h0) begin errors++; $display("FAIL rst_insn got %h want 0", fu_if.insn); end
        checks++; if (fu_if.insn_pc !== 32'h0) begin errors++; $display("FAIL rst_insn_pc got %h want 0", fu_if.insn_pc); end
        checks++; if (fu_if.mem_enable !== 1'b0) begin errors++; $display("FAIL rst_enable got %0b want 0", fu_if.mem_enable); end
        checks++; if (fu_if.mem_address !== 32'h0) begin errors++; $display("FAIL rst_address got %h want 0", fu_if.mem_address); end
        checks++; if ({fu_if.mem_rw, fu_if.mem_access_size, fu_if.mem_data_in} !== 35'h0) begin
            errors++; $display("FAIL rst_const got rw=%0b size=%b din=%h want 0/00/0", fu_if.mem_rw, fu_if.mem_access_size, fu_if.mem_data_in);
        end
    endtask

    // Also drives a redirect during the reset-release cycle, which must be ignored.
    task automatic test_first_fetch();
        reset_n              = 1'b1;
        fu_if.redirect_valid = 1'b1;
        fu_if.redirect_pc    = 32'h1234_5678;
        checks++; if (fu_if.mem_enable !== 1'b0) begin errors++; $display("FAIL c1_enable got %0b want 0", fu_if.mem_enable); end
        cyc();
        fu_if.redirect_valid = 1'b0;
        checks++; if (fu_if.mem_enable !== 1'b1 || fu_if.mem_address !== 32'h8002_0000) begin
            errors++; $display("FAIL c2_fetch got en=%0b addr=%h want 1/80020000", fu_if.mem_enable, fu_if.mem_address);
        end
        cyc();
        checks++; if (fu_if.mem_enable !== 1'b0 || fu_if.insn_valid !== 1'b0) begin
            errors++; $display("FAIL c3_wait got en=%0b vld=%0b want 0/0", fu_if.mem_enable, fu_if.insn_valid);
        end
        cyc();
        checks++; if (fu_if.insn_valid !== 1'b1 || fu_if.insn !== 32'h27BD_FFF8 || fu_if.insn_pc !== 32'h8002_0000) begin
            errors++; $display("FAIL c4_insn got vld=%0b insn=%h pc=%h want 1/27bdfff8/80020000", fu_if.insn_valid, fu_if.insn, fu_if.insn_pc);
        end
        cyc();
        checks++; if (fu_if.insn_valid !== 1'b0 || fu_if.mem_enable !== 1'b1 || fu_if.mem_address !== 32'h8002_0004) begin
            errors++; $display("FAIL c5_next got vld=%0b en=%0b addr=%h want 0/1/80020004", fu_if.insn_valid, fu_if.mem_enable, fu_if.mem_address);
        end
    endtask

    task automatic test_busy();
        int acc0;
        acc0 = mem_accepts;
        for (int i = 0; i < 3; i++) begin
            fu_if.mem_busy = 1'b1;
            checks++; if (fu_if.mem_enable !== 1'b1 || fu_if.mem_address !== 32'h8002_0004) begin
                errors++; $display("FAIL busy_hold%0d got en=%0b addr=%h want 1/80020004", i, fu_if.mem_enable, fu_if.mem_address);
            end
            cyc();
        end
        checks++; if (mem_accepts !== acc0) begin errors++; $display("FAIL busy_noaccept got %0d want %0d", mem_accepts, acc0); end
        fu_if.mem_busy   = 1'b0;
        fu_if.insn_ready = 1'b0;
        checks++; if (fu_if.mem_enable !== 1'b1 || fu_if.mem_address !== 32'h8002_0004) begin
            errors++; $display("FAIL busy_4th got en=%0b addr=%h want 1/80020004", fu_if.mem_enable, fu_if.mem_address);
        end
        cyc();
        checks++; if (fu_if.mem_enable !== 1'b0 || mem_accepts !== acc0 + 1) begin
            errors++; $display("FAIL busy_single got en=%0b accepts=%0d want 0/%0d", fu_if.mem_enable, mem_accepts, acc0 + 1);
        end
        cyc();
        checks++; if (fu_if.insn_valid !== 1'b1 || fu_if.insn_pc !== 32'h8002_0004 || fu_if.insn !== mem_word(32'h8002_0004)) begin
            errors++; $display("FAIL busy_capture got vld=%0b pc=%h insn=%h want 1/80020004/%h", fu_if.insn_valid, fu_if.insn_pc, fu_if.insn, mem_word(32'h8002_0004));
        end
    endtask

    task automatic test_hold_stall();
        int acc0;
        acc0 = mem_accepts;
        for (int i = 0; i < 5; i++) begin
            checks++; if (fu_if.insn_valid !== 1'b1 || fu_if.insn_pc !== 32'h8002_0004 || fu_if.insn !== mem_word(32'h8002_0004) || fu_if.mem_enable !== 1'b0) begin
                errors++; $display("FAIL stall%0d got vld=%0b pc=%h insn=%h en=%0b want 1/80020004/%h/0", i, fu_if.insn_valid, fu_if.insn_pc, fu_if.insn, fu_if.mem_enable, mem_word(32'h8002_0004));
            end
            cyc();
        end
        checks++; if (mem_accepts !== acc0) begin errors++; $display("FAIL stall_noreq got %0d want %0d", mem_accepts, acc0); end
        fu_if.insn_ready = 1'b1;
        cyc();
        checks++; if (fu_if.insn_valid !== 1'b0 || fu_if.mem_enable !== 1'b1 || fu_if.mem_address !== 32'h8002_0008) begin
            errors++; $display("FAIL stall_release got vld=%0b en=%0b addr=%h want 0/1/80020008", fu_if.insn_valid, fu_if.mem_enable, fu_if.mem_address);
        end
    endtask

    task automatic test_redirect_wait();
        cyc();   // FETCH accepted -> WAIT
        fu_if.redirect_valid = 1'b1;
        fu_if.redirect_pc    = 32'h8002_0103;
        cyc();
        fu_if.redirect_valid = 1'b0;
        checks++; if (fu_if.insn_valid !== 1'b0 || fu_if.mem_enable !== 1'b1 || fu_if.mem_address !== 32'h8002_0100) begin
            errors++; $display("FAIL rdw_fetch got vld=%0b en=%0b addr=%h want 0/1/80020100", fu_if.insn_valid, fu_if.mem_enable, fu_if.mem_address);
        end
        checks++; if (fu_if.insn_pc !== 32'h8002_0004 || fu_if.insn !== mem_word(32'h8002_0004)) begin
            errors++; $display("FAIL rdw_keep got pc=%h insn=%h want 80020004/%h", fu_if.insn_pc, fu_if.insn, mem_word(32'h8002_0004));
        end
        cyc();
        checks++; if (fu_if.insn_valid !== 1'b0) begin errors++; $display("FAIL rdw_nopulse got %0b want 0", fu_if.insn_valid); end
        cyc();
        checks++; if (fu_if.insn_valid !== 1'b1 || fu_if.insn_pc !== 32'h8002_0100 || fu_if.insn !== mem_word(32'h8002_0100)) begin
            errors++; $display("FAIL rdw_capture got vld=%0b pc=%h insn=%h want 1/80020100/%h", fu_if.insn_valid, fu_if.insn_pc, fu_if.insn, mem_word(32'h8002_0100));
        end
    endtask

    task automatic test_redirect_hold();
        logic [31:0] tgt, tgt_al;
        tgt    = $urandom;
        tgt_al = tgt & 32'hFFFF_FFFC;
        fu_if.insn_ready     = 1'b1;
        fu_if.redirect_valid = 1'b1;
        fu_if.redirect_pc    = tgt;
        cyc();
        fu_if.redirect_valid = 1'b0;
        checks++; if (fu_if.insn_valid !== 1'b0 || fu_if.mem_enable !== 1'b1 || fu_if.mem_address !== tgt_al || fu_if.insn_pc !== 32'h8002_0100) begin
            errors++; $display("FAIL rdh_drop got vld=%0b en=%0b addr=%h pc=%h want 0/1/%h/80020100", fu_if.insn_valid, fu_if.mem_enable, fu_if.mem_address, fu_if.insn_pc, tgt_al);
        end
        cyc();
        cyc();
        checks++; if (fu_if.insn_valid !== 1'b1 || fu_if.insn_pc !== tgt_al || fu_if.insn !== mem_word(tgt_al)) begin
            errors++; $display("FAIL rdh_next got vld=%0b pc=%h insn=%h want 1/%h/%h", fu_if.insn_valid, fu_if.insn_pc, fu_if.insn, tgt_al, mem_word(tgt_al));
        end
        cyc();
        checks++; if (fu_if.mem_enable !== 1'b1 || fu_if.mem_address !== tgt_al + 32'd4) begin
            errors++; $display("FAIL rdh_seq got en=%0b addr=%h want 1/%h", fu_if.mem_enable, fu_if.mem_address, tgt_al + 32'd4);
        end
    endtask

    task automatic test_wrap_and_reset();
        fu_if.redirect_valid = 1'b1;
        fu_if.redirect_pc    = 32'hFFFF_FFFE;
        cyc();
        fu_if.redirect_valid = 1'b0;
        checks++; if (fu_if.mem_address !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_fetch got %h want fffffffc", fu_if.mem_address); end
        cyc();
        cyc();
        checks++; if (fu_if.insn_valid !== 1'b1 || fu_if.insn_pc !== 32'hFFFF_FFFC || fu_if.insn !== mem_word(32'hFFFF_FFFC)) begin
            errors++; $display("FAIL wrap_insn got vld=%0b pc=%h insn=%h want 1/fffffffc/%h", fu_if.insn_valid, fu_if.insn_pc, fu_if.insn, mem_word(32'hFFFF_FFFC));
        end
        cyc();
        checks++; if (fu_if.mem_enable !== 1'b1 || fu_if.mem_address !== 32'h0) begin
            errors++; $display("FAIL wrap_zero got en=%0b addr=%h want 1/00000000", fu_if.mem_enable, fu_if.mem_address);
        end
        // redirect while the memory is busy: new address on the next cycle
        fu_if.mem_busy       = 1'b1;
        fu_if.redirect_valid = 1'b1;
        fu_if.redirect_pc    = 32'h8002_0040;
        cyc();
        fu_if.redirect_valid = 1'b0;
        checks++; if (fu_if.mem_enable !== 1'b1 || fu_if.mem_address !== 32'h8002_0040) begin
            errors++; $display("FAIL busy_redirect got en=%0b addr=%h want 1/80020040", fu_if.mem_enable, fu_if.mem_address);
        end
        fu_if.mem_busy = 1'b0;
        cyc();   // WAIT with a read in flight
        reset_n = 1'b0;
        #1;
        checks++; if (fu_if.insn_valid !== 1'b0 || fu_if.insn !== 32'h0 || fu_if.insn_pc !== 32'h0 || fu_if.mem_enable !== 1'b0 || fu_if.mem_address !== 32'h0) begin
            errors++; $display("FAIL async_rst got vld=%0b insn=%h pc=%h en=%0b addr=%h want all 0", fu_if.insn_valid, fu_if.insn, fu_if.insn_pc, fu_if.mem_enable, fu_if.mem_address);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        cyc();
        checks++; if (fu_if.mem_enable !== 1'b1 || fu_if.mem_address !== 32'h8002_0000 || fu_if.insn !== 32'h0 || fu_if.insn_valid !== 1'b0) begin
            errors++; $display("FAIL rst_refetch got en=%0b addr=%h insn=%h vld=%0b want 1/80020000/0/0", fu_if.mem_enable, fu_if.mem_address, fu_if.insn, fu_if.insn_valid);
        end
        cyc();
        cyc();
        checks++; if (fu_if.insn_valid !== 1'b1 || fu_if.insn !== 32'h27BD_FFF8 || fu_if.insn_pc !== 32'h8002_0000) begin
            errors++; $display("FAIL rst_capture got vld=%0b insn=%h pc=%h want 1/27bdfff8/80020000", fu_if.insn_valid, fu_if.insn, fu_if.insn_pc);
        end
    endtask

    // Model: exp_pc is the address of the next instruction decode will accept.
    // An accepted instruction must be {mem[exp_pc], exp_pc}; a redirect replaces exp_pc.
    task automatic test_random();
        logic [31:0] exp_pc, prev_insn, prev_pc, prev_addr;
        logic        hold_prev, busy_prev, rd;
        int          accepted;
        exp_pc    = 32'h8002_0000;
        hold_prev = 1'b0;
        busy_prev = 1'b0;
        prev_insn = '0;
        prev_pc   = '0;
        prev_addr = '0;
        accepted  = 0;
        for (int cyc_n = 0; cyc_n < 3000; cyc_n++) begin
            if (hold_prev) begin
                checks++; if (fu_if.insn_valid !== 1'b1 || fu_if.insn !== prev_insn || fu_if.insn_pc !== prev_pc) begin
                    errors++; $display("FAIL rnd_hold cyc %0d got vld=%0b insn=%h pc=%h want 1/%h/%h", cyc_n, fu_if.insn_valid, fu_if.insn, fu_if.insn_pc, prev_insn, prev_pc);
                end
            end
            if (busy_prev) begin
                checks++; if (fu_if.mem_enable !== 1'b1 || fu_if.mem_address !== prev_addr) begin
                    errors++; $display("FAIL rnd_busy cyc %0d got en=%0b addr=%h want 1/%h", cyc_n, fu_if.mem_enable, fu_if.mem_address, prev_addr);
                end
            end
            fu_if.mem_busy   = ($urandom_range(3) == 0);
            fu_if.insn_ready = ($urandom_range(2) != 0);
            rd               = ($urandom_range(15) == 0);
            fu_if.redirect_valid = rd;
            fu_if.redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : 32'($urandom);
            if (rd) begin
                exp_pc = fu_if.redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (fu_if.mem_enable && !fu_if.mem_busy) begin
                    checks++; if (fu_if.mem_address !== exp_pc) begin
                        errors++; $display("FAIL rnd_addr cyc %0d got %h want %h", cyc_n, fu_if.mem_address, exp_pc);
                    end
                end
                if (fu_if.insn_valid && fu_if.insn_ready) begin
                    checks++; if (fu_if.insn_pc !== exp_pc || fu_if.insn !== mem_word(exp_pc)) begin
                        errors++; $display("FAIL rnd_insn cyc %0d got pc=%h insn=%h want %h/%h", cyc_n, fu_if.insn_pc, fu_if.insn, exp_pc, mem_word(exp_pc));
                    end
                    accepted++;
                    exp_pc = exp_pc + 32'd4;
                end
            end
            hold_prev = fu_if.insn_valid && !fu_if.insn_ready && !rd;
            busy_prev = fu_if.mem_enable && fu_if.mem_busy && !rd;
            prev_insn = fu_if.insn;
            prev_pc   = fu_if.insn_pc;
            prev_addr = fu_if.mem_address;
            cyc();
        end
        fu_if.redirect_valid = 1'b0;
        checks++; if (accepted < 100) begin errors++; $display("FAIL rnd_progress got %0d accepted want >= 100", accepted); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_busy();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
